// File: rtl/mem_stage_bytelane_if.sv
// EX/MEM -> MEM/WB bundle for the MEM stage, plus the seven-segment debug read port.
// The master drives the EX/MEM side and the debug controls; the slave is the stage itself.
interface mem_stage_bytelane_if #(
  parameter int ADDR_W = 7
);
  logic              stall;
  logic              ex_regwrite;
  logic              ex_memtoreg;
  logic              ex_memwrite;
  logic [4:0]        ex_rd;
  logic [31:0]       ex_alu_result;
  logic [31:0]       ex_wdata;
  logic [2:0]        ex_ltype;
  logic [2:0]        ex_stype;
  logic              dbg_auto;
  logic [ADDR_W-1:0] dbg_addr;
  logic              wb_regwrite;
  logic              wb_memtoreg;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_alu_result;
  logic [31:0]       wb_load_data;
  logic              misalign_exc;
  logic [31:0]       dbg_data;
  logic [ADDR_W-1:0] dbg_cur_addr;

  modport master (
    output stall, ex_regwrite, ex_memtoreg, ex_memwrite, ex_rd, ex_alu_result,
           ex_wdata, ex_ltype, ex_stype, dbg_auto, dbg_addr,
    input  wb_regwrite, wb_memtoreg, wb_rd, wb_alu_result, wb_load_data,
           misalign_exc, dbg_data, dbg_cur_addr
  );

  modport slave (
    input  stall, ex_regwrite, ex_memtoreg, ex_memwrite, ex_rd, ex_alu_result,
           ex_wdata, ex_ltype, ex_stype, dbg_auto, dbg_addr,
    output wb_regwrite, wb_memtoreg, wb_rd, wb_alu_result, wb_load_data,
           misalign_exc, dbg_data, dbg_cur_addr
  );
endinterface

// File: rtl/mem_stage_bytelane.sv
// MIPS MEM stage: byte-lane data memory with partial/unaligned stores, load alignment,
// misalign detection, registered MEM/WB bank and an auto-scanning debug read port.
module mem_stage_bytelane #(
  parameter int ADDR_W   = 7,
  parameter int SCAN_DIV = 10000000
) (
  input logic              i_clk,
  input logic              i_rst,
  mem_stage_bytelane_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [2:0] {
    LD_NONE, LD_LW, LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LWL, LD_LWR
  } ltype_e;

  typedef enum logic [2:0] {
    ST_NONE, ST_SW, ST_SB, ST_SH, ST_SWL, ST_SWR, ST_RSV6, ST_RSV7
  } stype_e;

  logic [31:0]       r_mem [DEPTH];

  logic              r_wbRegwrite;
  logic              r_wbMemtoreg;
  logic [4:0]        r_wbRd;
  logic [31:0]       r_wbAluResult;
  logic [31:0]       r_wbLoadData;
  logic              r_misalignExc;

  logic [DIV_W-1:0]  r_div;
  logic [ADDR_W-1:0] r_scan;
  logic [ADDR_W-1:0] r_dbgCur;
  logic [31:0]       r_dbgData;

  ltype_e            w_ltype;
  stype_e            w_stype;
  logic [ADDR_W-1:0] w_widx;
  logic [1:0]        w_off;
  logic [31:0]       w_rword;
  logic [31:0]       w_rShift;
  logic [31:0]       w_rt;
  logic [31:0]       w_loadData;
  logic              w_misalign;
  logic [3:0]        w_be;
  logic [31:0]       w_sdata;
  logic              w_wen;
  logic              w_divWrap;
  logic [ADDR_W-1:0] w_scanNext;
  logic              w_unusedAddrBits;

  assign w_ltype          = ltype_e'(bus.ex_ltype);
  assign w_stype          = stype_e'(bus.ex_stype);
  assign w_widx           = bus.ex_alu_result[ADDR_W+1:2];
  assign w_off            = bus.ex_alu_result[1:0];
  assign w_rt             = bus.ex_wdata;
  assign w_rword          = r_mem[w_widx];
  assign w_rShift         = w_rword >> {w_off, 3'b000};
  assign w_unusedAddrBits = ^bus.ex_alu_result[31:ADDR_W+2];

  // Word accesses need offset 0, halfword accesses an even offset
  always_comb begin
    w_misalign = 1'b0;
    if (w_ltype == LD_LW && w_off != 2'd0)
      w_misalign = 1'b1;
    if ((w_ltype == LD_LH || w_ltype == LD_LHU) && w_off[0])
      w_misalign = 1'b1;
    if (bus.ex_memwrite && w_stype == ST_SW && w_off != 2'd0)
      w_misalign = 1'b1;
    if (bus.ex_memwrite && w_stype == ST_SH && w_off[0])
      w_misalign = 1'b1;
  end

  always_comb begin
    w_loadData = 32'd0;
    case (w_ltype)
      LD_LW:  w_loadData = w_rword;
      LD_LB:  w_loadData = {{24{w_rShift[7]}}, w_rShift[7:0]};
      LD_LBU: w_loadData = {24'd0, w_rShift[7:0]};
      LD_LH:  w_loadData = {{16{w_rShift[15]}}, w_rShift[15:0]};
      LD_LHU: w_loadData = {16'd0, w_rShift[15:0]};
      LD_LWL: begin
        case (w_off)
          2'd0:    w_loadData = {w_rword[7:0],  w_rt[23:0]};
          2'd1:    w_loadData = {w_rword[15:0], w_rt[15:0]};
          2'd2:    w_loadData = {w_rword[23:0], w_rt[7:0]};
          default: w_loadData = w_rword;
        endcase
      end
      LD_LWR: begin
        case (w_off)
          2'd0:    w_loadData = w_rword;
          2'd1:    w_loadData = {w_rt[31:24], w_rword[31:8]};
          2'd2:    w_loadData = {w_rt[31:16], w_rword[31:16]};
          default: w_loadData = {w_rt[31:8],  w_rword[31:24]};
        endcase
      end
      default: w_loadData = 32'd0;
    endcase
  end

  // Store data is pre-rotated so lane k of w_sdata is what lane k of memory receives
  always_comb begin
    w_be    = 4'b0000;
    w_sdata = 32'd0;
    case (w_stype)
      ST_SW: begin
        w_be    = 4'b1111;
        w_sdata = w_rt;
      end
      ST_SB: begin
        w_be    = 4'b0001 << w_off;
        w_sdata = {4{w_rt[7:0]}};
      end
      ST_SH: begin
        w_be    = 4'b0011 << w_off;
        w_sdata = {2{w_rt[15:0]}};
      end
      ST_SWL: begin
        w_be    = 4'b1111 >> (2'd3 - w_off);
        w_sdata = w_rt >> {(2'd3 - w_off), 3'b000};
      end
      ST_SWR: begin
        w_be    = 4'b1111 << w_off;
        w_sdata = w_rt << {w_off, 3'b000};
      end
      default: begin
        w_be    = 4'b0000;
        w_sdata = 32'd0;
      end
    endcase
  end

  assign w_wen = bus.ex_memwrite & ~bus.stall & ~w_misalign;

  always_ff @(posedge i_clk) begin
    if (w_wen) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k])
          r_mem[w_widx][8*k +: 8] <= w_sdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wbRegwrite  <= 1'b0;
      r_wbMemtoreg  <= 1'b0;
      r_wbRd        <= 5'd0;
      r_wbAluResult <= 32'd0;
      r_wbLoadData  <= 32'd0;
      r_misalignExc <= 1'b0;
    end else if (!bus.stall) begin
      r_wbRegwrite  <= bus.ex_regwrite & ~w_misalign;
      r_wbMemtoreg  <= bus.ex_memtoreg;
      r_wbRd        <= bus.ex_rd;
      r_wbAluResult <= bus.ex_alu_result;
      r_wbLoadData  <= w_loadData;
      r_misalignExc <= w_misalign;
    end
  end

  assign w_divWrap  = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_scanNext = w_divWrap ? r_scan + 1'b1 : r_scan;

  // Displayed address is registered, so the word shown trails it by one cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div     <= '0;
      r_scan    <= '0;
      r_dbgCur  <= '0;
      r_dbgData <= 32'd0;
    end else begin
      if (bus.dbg_auto) begin
        r_div    <= w_divWrap ? '0 : r_div + 1'b1;
        r_scan   <= w_scanNext;
        r_dbgCur <= w_scanNext;
      end else begin
        r_dbgCur <= bus.dbg_addr;
      end
      r_dbgData <= r_mem[r_dbgCur];
    end
  end

  assign bus.wb_regwrite   = r_wbRegwrite;
  assign bus.wb_memtoreg   = r_wbMemtoreg;
  assign bus.wb_rd         = r_wbRd;
  assign bus.wb_alu_result = r_wbAluResult;
  assign bus.wb_load_data  = r_wbLoadData;
  assign bus.misalign_exc  = r_misalignExc;
  assign bus.dbg_data      = r_dbgData;
  assign bus.dbg_cur_addr  = r_dbgCur;

endmodule

// File: tb/tb_mem_stage_bytelane.sv
// Bench for mem_stage_bytelane: directed plus random traffic against a byte-level
// reference memory, and debug-port scan checks with a short scan divider.
module tb_mem_stage_bytelane;

  localparam int ADDR_W   = 7;
  localparam int SCAN_DIV = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_stage_bytelane_if #(.ADDR_W(ADDR_W)) bus ();

  mem_stage_bytelane #(.ADDR_W(ADDR_W), .SCAN_DIV(SCAN_DIV)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] refMem [DEPTH];
  logic        eRegwrite, eMemtoreg, eMis, loadValid;
  logic [4:0]  eRd;
  logic [31:0] eAlu, eLoad;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic modelMis(input logic [1:0] b, input int lt, input int st, input logic mw);
    if (lt == 1 && b != 0) return 1'b1;
    if ((lt == 4 || lt == 5) && b % 2 == 1) return 1'b1;
    if (mw && st == 1 && b != 0) return 1'b1;
    if (mw && st == 3 && b % 2 == 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] w, input int b, input int lt,
                                            input logic [31:0] rt);
    logic [7:0] mb [4];
    logic [7:0] res [4];
    logic [15:0] h;
    for (int i = 0; i < 4; i++) begin
      mb[i]  = w[8*i +: 8];
      res[i] = rt[8*i +: 8];
    end
    case (lt)
      1: return w;
      2: return {{24{mb[b][7]}}, mb[b]};
      3: return {24'd0, mb[b]};
      4, 5: begin
        if (b > 2) return 32'd0;
        h = {mb[b+1], mb[b]};
        return (lt == 4) ? {{16{h[15]}}, h} : {16'd0, h};
      end
      6: for (int i = 0; i <= b; i++) res[3-b+i] = mb[i];
      7: for (int i = b; i < 4; i++) res[i-b] = mb[i];
      default: return 32'd0;
    endcase
    return {res[3], res[2], res[1], res[0]};
  endfunction

  function automatic logic [31:0] modelStore(input logic [31:0] w, input int b, input int st,
                                             input logic [31:0] rt);
    logic [7:0] rb [4];
    logic [7:0] res [4];
    for (int i = 0; i < 4; i++) begin
      rb[i]  = rt[8*i +: 8];
      res[i] = w[8*i +: 8];
    end
    case (st)
      1: return rt;
      2: res[b] = rb[0];
      3: begin
        res[b]   = rb[0];
        res[b+1] = rb[1];
      end
      4: for (int i = 0; i <= b; i++) res[i] = rb[3-b+i];
      5: for (int i = b; i < 4; i++) res[i] = rb[i-b];
      default: ;
    endcase
    return {res[3], res[2], res[1], res[0]};
  endfunction

  task automatic driveIdle();
    bus.stall         = 1'b0;
    bus.ex_regwrite   = 1'b0;
    bus.ex_memtoreg   = 1'b0;
    bus.ex_memwrite   = 1'b0;
    bus.ex_rd         = 5'd0;
    bus.ex_alu_result = 32'd0;
    bus.ex_wdata      = 32'd0;
    bus.ex_ltype      = 3'd0;
    bus.ex_stype      = 3'd0;
  endtask

  task automatic applyStimulus(input logic iStall, input logic iRw, input logic [4:0] iRd,
                               input logic [31:0] iAddr, input logic [31:0] iWd,
                               input logic [2:0] iLt, input logic [2:0] iSt, input logic iMw);
    int          idx;
    int          b;
    logic        mis;
    logic [31:0] old;
    idx = int'(iAddr[ADDR_W+1:2]);
    b   = int'(iAddr[1:0]);
    mis = modelMis(iAddr[1:0], int'(iLt), int'(iSt), iMw);
    old = refMem[idx];
    if (!iStall) begin
      eRegwrite = iRw & ~mis;
      eMemtoreg = (iLt != 3'd0);
      eRd       = iRd;
      eAlu      = iAddr;
      eLoad     = modelLoad(old, b, int'(iLt), iWd);
      eMis      = mis;
      loadValid = ~mis;
      if (iMw && !mis) refMem[idx] = modelStore(old, b, int'(iSt), iWd);
    end
    bus.stall         = iStall;
    bus.ex_regwrite   = iRw;
    bus.ex_memtoreg   = (iLt != 3'd0);
    bus.ex_memwrite   = iMw;
    bus.ex_rd         = iRd;
    bus.ex_alu_result = iAddr;
    bus.ex_wdata      = iWd;
    bus.ex_ltype      = iLt;
    bus.ex_stype      = iSt;
    @(posedge clk);
    #1;
    checkOutput("wb_regwrite", 32'(bus.wb_regwrite), 32'(eRegwrite));
    checkOutput("wb_memtoreg", 32'(bus.wb_memtoreg), 32'(eMemtoreg));
    checkOutput("wb_rd", 32'(bus.wb_rd), 32'(eRd));
    checkOutput("wb_alu_result", bus.wb_alu_result, eAlu);
    checkOutput("misalign_exc", 32'(bus.misalign_exc), 32'(eMis));
    if (loadValid) checkOutput("wb_load_data", bus.wb_load_data, eLoad);
    driveIdle();
  endtask

  task automatic applyReset();
    driveIdle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    eRegwrite = 1'b0;
    eMemtoreg = 1'b0;
    eRd       = 5'd0;
    eAlu      = 32'd0;
    eLoad     = 32'd0;
    eMis      = 1'b0;
    loadValid = 1'b1;
    checkOutput("rst_wb_regwrite", 32'(bus.wb_regwrite), 32'd0);
    checkOutput("rst_wb_memtoreg", 32'(bus.wb_memtoreg), 32'd0);
    checkOutput("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    checkOutput("rst_wb_alu_result", bus.wb_alu_result, 32'd0);
    checkOutput("rst_wb_load_data", bus.wb_load_data, 32'd0);
    checkOutput("rst_misalign_exc", 32'(bus.misalign_exc), 32'd0);
    checkOutput("rst_dbg_data", bus.dbg_data, 32'd0);
    checkOutput("rst_dbg_cur_addr", 32'(bus.dbg_cur_addr), 32'd0);
  endtask

  initial begin
    driveIdle();
    bus.dbg_auto = 1'b0;
    bus.dbg_addr = '0;
    rst          = 1'b0;
    @(negedge clk);
    applyReset();

    // Give every word a known value so the model and memory agree everywhere
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b0, 5'd0, 32'(i * 4), $urandom, 3'd0, 3'd1, 1'b1);

    // Partial stores merged into one word
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h10, 32'h11223344, 3'd0, 3'd1, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h11, 32'h000000AA, 3'd0, 3'd2, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h12, 32'h0000BEEF, 3'd0, 3'd3, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h10, 32'd0, 3'd1, 3'd0, 1'b0);
    checkOutput("plan_sb_sh_merge", bus.wb_load_data, 32'hBEEFAA44);

    // Sign/zero extension
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h20, 32'h8000F07F, 3'd0, 3'd1, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd4, 32'h20, 32'd0, 3'd2, 3'd0, 1'b0);
    checkOutput("plan_lb20", bus.wb_load_data, 32'h0000007F);
    applyStimulus(1'b0, 1'b1, 5'd4, 32'h21, 32'd0, 3'd2, 3'd0, 1'b0);
    checkOutput("plan_lb21", bus.wb_load_data, 32'hFFFFFFF0);
    applyStimulus(1'b0, 1'b1, 5'd4, 32'h21, 32'd0, 3'd3, 3'd0, 1'b0);
    checkOutput("plan_lbu21", bus.wb_load_data, 32'h000000F0);
    applyStimulus(1'b0, 1'b1, 5'd4, 32'h22, 32'd0, 3'd4, 3'd0, 1'b0);
    checkOutput("plan_lh22", bus.wb_load_data, 32'hFFFF8000);
    applyStimulus(1'b0, 1'b1, 5'd4, 32'h22, 32'd0, 3'd5, 3'd0, 1'b0);
    checkOutput("plan_lhu22", bus.wb_load_data, 32'h00008000);

    // Unaligned left/right pairs
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h30, 32'h44332211, 3'd0, 3'd1, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd5, 32'h31, 32'hAAAAAAAA, 3'd6, 3'd0, 1'b0);
    checkOutput("plan_lwl31", bus.wb_load_data, 32'h2211AAAA);
    applyStimulus(1'b0, 1'b1, 5'd5, 32'h31, 32'hAAAAAAAA, 3'd7, 3'd0, 1'b0);
    checkOutput("plan_lwr31", bus.wb_load_data, 32'hAA443322);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h31, 32'hDDCCBBAA, 3'd0, 3'd4, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd5, 32'h30, 32'd0, 3'd1, 3'd0, 1'b0);
    checkOutput("plan_swl31", bus.wb_load_data, 32'h4433DDCC);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h30, 32'h44332211, 3'd0, 3'd1, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h31, 32'hDDCCBBAA, 3'd0, 3'd5, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd5, 32'h30, 32'd0, 3'd1, 3'd0, 1'b0);
    checkOutput("plan_swr31", bus.wb_load_data, 32'hCCBBAA11);

    // Misaligned store and load
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h40, 32'h12345678, 3'd0, 3'd1, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd6, 32'h42, 32'hFFFFFFFF, 3'd0, 3'd1, 1'b1);
    checkOutput("plan_sw_mis_exc", 32'(bus.misalign_exc), 32'd1);
    applyStimulus(1'b0, 1'b1, 5'd6, 32'h43, 32'd0, 3'd4, 3'd0, 1'b0);
    checkOutput("plan_lh_mis_exc", 32'(bus.misalign_exc), 32'd1);
    checkOutput("plan_lh_mis_rw", 32'(bus.wb_regwrite), 32'd0);
    applyStimulus(1'b0, 1'b1, 5'd6, 32'h40, 32'd0, 3'd1, 3'd0, 1'b0);
    checkOutput("plan_mis_nowrite", bus.wb_load_data, 32'h12345678);
    checkOutput("plan_mis_clears", 32'(bus.misalign_exc), 32'd0);

    // Stalled store must not write and must hold the WB bank
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h50, 32'hCAFEF00D, 3'd0, 3'd1, 1'b1);
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h50, 32'h0BADBEEF, 3'd1, 3'd1, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h50, 32'd0, 3'd1, 3'd0, 1'b0);
    checkOutput("plan_stall_nowrite", bus.wb_load_data, 32'hCAFEF00D);

    // Reset mid-operation keeps memory
    applyReset();
    applyStimulus(1'b0, 1'b1, 5'd8, 32'h10, 32'd0, 3'd1, 3'd0, 1'b0);
    checkOutput("plan_rst_keepmem", bus.wb_load_data, 32'hBEEFAA44);

    // Random traffic, upper address bits exercise the wrap
    for (int n = 0; n < 400; n++)
      applyStimulus(($urandom_range(0, 7) == 0), 1'($urandom), 5'($urandom), $urandom,
                    $urandom, 3'($urandom), 3'($urandom), 1'($urandom));

    // Manual debug address, including a store seen one cycle after its edge
    bus.dbg_addr = 7'd5;
    @(posedge clk);
    #1;
    checkOutput("dbg_manual_addr", 32'(bus.dbg_cur_addr), 32'd5);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h14, 32'h5A5AA5A5, 3'd0, 3'd1, 1'b1);
    checkOutput("dbg_manual_data", 32'(bus.dbg_cur_addr), 32'd5);
    @(posedge clk);
    #1;
    checkOutput("dbg_store_visible", bus.dbg_data, 32'h5A5AA5A5);

    // Auto-scan from reset: address steps every SCAN_DIV cycles and wraps
    bus.dbg_auto = 1'b1;
    applyReset();
    for (int k = 1; k <= 4 * DEPTH + 20; k++) begin
      @(posedge clk);
      #1;
      checkOutput("dbg_scan_addr", 32'(bus.dbg_cur_addr), 32'((k / SCAN_DIV) % DEPTH));
      checkOutput("dbg_scan_data", bus.dbg_data, refMem[((k - 1) / SCAN_DIV) % DEPTH]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_bytelane.md
Name: mem_stage_bytelane

Overview:
Parametrised MEM pipeline stage for the 5-stage MIPS core. It holds a word-organised data memory with per-byte write lanes and implements SB/SH/SW/SWL/SWR stores. It also implements LB/LBU/LH/LHU/LW/LWL/LWR load alignment and extension, misaligned-access detection, and a registered MEM/WB output bank. A second read-only debug port feeds the seven-segment display path, with a manual or auto-scanning address.

Parameters:
ADDR_W, 7, word-address bits; memory depth = 2^ADDR_W 32-bit words
SCAN_DIV, 10000000, clock cycles per debug auto-scan step (>=1)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold MEM/WB registers and suppress the memory write
ex_regwrite  in  1  EX/MEM register-write control
ex_memtoreg  in  1  EX/MEM writeback-select control
ex_memwrite  in  1  store enable
ex_rd  in  5  destination register
ex_alu_result  in  32  effective byte address / ALU result
ex_wdata  in  32  rt value: store data, and the old rt value for LWL/LWR
ex_ltype  in  3  0 none, 1 LW, 2 LB, 3 LBU, 4 LH, 5 LHU, 6 LWL, 7 LWR
ex_stype  in  3  0 none, 1 SW, 2 SB, 3 SH, 4 SWL, 5 SWR, 6-7 none
dbg_auto  in  1  1 = auto-scan address, 0 = use dbg_addr
dbg_addr  in  ADDR_W  manual debug word address
wb_regwrite  out  1  registered regwrite (forced 0 on misalign)
wb_memtoreg  out  1  registered memtoreg
wb_rd  out  5  registered destination register
wb_alu_result  out  32  registered ALU result
wb_load_data  out  32  registered aligned/extended load result
misalign_exc  out  1  registered one-cycle misaligned-access flag
dbg_data  out  32  registered word at the current debug address
dbg_cur_addr  out  ADDR_W  debug address currently displayed

Behaviour:
- Reset: one clock; reset is synchronous and active-high. All outputs, the scan address and the divider reset to 0. Memory contents are not reset.
- Addressing: word index = ex_alu_result[ADDR_W+1:2]; byte offset b = ex_alu_result[1:0]; higher bits ignored, so addresses wrap. Byte order is little-endian: byte k = word[8k+7:8k].
- Misalign: LW/SW with b!=0, or LH/LHU/SH with b[0]=1. Registered next edge: misalign_exc=1 for one cycle, wb_regwrite=0, store suppressed.
- Store lanes (write at rising edge when ex_memwrite & ~stall & ~misalign; other lanes unchanged):
  - SW: all 4 lanes.
  - SB: lane b gets rt[7:0].
  - SH: lanes b, b+1 get rt[15:0].
  - SWL: lanes 0..b get rt bytes (3-b)..3.
  - SWR: lanes b..3 get rt bytes 0..(3-b).
  - ex_memwrite with stype none: no write.
- Load alignment (read is combinational from the current word, captured into wb_load_data at the edge):
  - LB/LH: sign-extend. LBU/LHU: zero-extend.
  - LWL: result bytes (3-b)..3 = mem bytes 0..b; remaining bytes from ex_wdata.
  - LWR: result bytes 0..(3-b) = mem bytes b..3; remaining bytes from ex_wdata.
  - ltype none: wb_load_data = 0.
- Latency: one cycle, EX/MEM inputs to wb_* outputs.
- Store then load to the same word in the next cycle returns the new data (write completes at the edge, before the next read).
- stall=1: every wb_* output and misalign_exc hold their previous value; no memory write.
- Debug scan:
  - Divider counts 0..SCAN_DIV-1.
  - On wrap with dbg_auto=1, scan address +1, wrapping 2^ADDR_W-1 to 0.
  - dbg_auto=0: dbg_cur_addr = dbg_addr; scan address and divider hold.
  - dbg_data = mem[dbg_cur_addr] registered, 1-cycle latency. It shows a same-edge store one cycle later.
  - The debug port is independent of stall.

Test Plan:
- Reset: assert rst 1 cycle mid-operation -> next edge all wb_*, misalign_exc, dbg_data, dbg_cur_addr = 0; memory retains prior contents.
- Byte stores: SW 0x11223344 @0x10, SB rt=0xAA @0x11, SH rt=0xBEEF @0x12 -> LW @0x10 yields 0xBEEFAA44 one cycle after issue.
- Loads with word 0x8000F07F @0x20: LB @0x20 = 0x0000007F; LB @0x21 = 0xFFFFFFF0; LBU @0x21 = 0x000000F0; LH @0x22 = 0xFFFF8000; LHU @0x22 = 0x00008000.
- Unaligned pair with mem[0x30]=0x44332211 and rt=0xAAAAAAAA:
  - LWL @0x31 -> 0x2211AAAA; LWR @0x31 -> 0xAA443322.
  - SWL rt=0xDDCCBBAA @0x31 -> word 0x4433DDCC; SWR rt=0xDDCCBBAA @0x31 -> word 0xCCBBAA11 (each from the original word).
- Misalign: SW @0x42, then LH @0x43 with ex_regwrite=1 -> misalign_exc=1 each next cycle; wb_regwrite=0; mem[0x40] unchanged.
- Stall/debug: stall=1 with SW -> no write, wb_* held. With SCAN_DIV=4 and dbg_auto=1, dbg_cur_addr steps every 4 cycles and wraps 127->0; dbg_data lags the address by 1 cycle.
